iob_fifo_sync_ctrl: RTL and testbench

// Synchronous FIFO controller that drives an external iob_2p_ram (1-cycle read latency).

---
 rtl/iob_fifo_sync_ctrl_if.sv | 41 ++++
 rtl/iob_fifo_sync_ctrl.sv | 92 +++++++++
 tb/tb_iob_fifo_sync_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/iob_fifo_sync_ctrl_if.sv
// Push/pop user bus plus the 2-port RAM side of the FIFO controller.
// slave is the controller view; master is the user-plus-RAM view.
interface iob_fifo_sync_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              w_en;
  logic [DATA_W-1:0] w_data;
  logic              w_full;
  logic              w_almost_full;
  logic              r_en;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_empty;
  logic              r_almost_empty;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underflow;
  logic              ext_mem_w_en;
  logic [ADDR_W-1:0] ext_mem_w_addr;
  logic [DATA_W-1:0] ext_mem_w_data;
  logic              ext_mem_r_en;
  logic [ADDR_W-1:0] ext_mem_r_addr;
  logic [DATA_W-1:0] ext_mem_r_data;

  modport slave (
    input  w_en, w_data, r_en, ext_mem_r_data,
    output w_full, w_almost_full, r_data, r_valid, r_empty, r_almost_empty,
           level, overflow, underflow,
           ext_mem_w_en, ext_mem_w_addr, ext_mem_w_data,
           ext_mem_r_en, ext_mem_r_addr
  );

  modport master (
    output w_en, w_data, r_en, ext_mem_r_data,
    input  w_full, w_almost_full, r_data, r_valid, r_empty, r_almost_empty,
           level, overflow, underflow,
           ext_mem_w_en, ext_mem_w_addr, ext_mem_w_data,
           ext_mem_r_en, ext_mem_r_addr
  );
endinterface

// File: rtl/iob_fifo_sync_ctrl.sv
// Synchronous FIFO controller for an external 2-port RAM with 1-cycle read latency.
// Push/pop are accepted from pre-edge flags only; rejected requests set sticky overflow/underflow.
module iob_fifo_sync_ctrl #(
  parameter int DATA_W           = 8,
  parameter int ADDR_W           = 4,
  parameter int ALMOST_FULL_LVL  = 14,
  parameter int ALMOST_EMPTY_LVL = 2
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  rst,
  iob_fifo_sync_ctrl_if.slave   bus
);

  localparam logic [ADDR_W:0] DEPTH  = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AF_LVL = (ADDR_W+1)'(ALMOST_FULL_LVL);
  localparam logic [ADDR_W:0] AE_LVL = (ADDR_W+1)'(ALMOST_EMPTY_LVL);
  localparam logic [ADDR_W:0] ONE    = (ADDR_W+1)'(1);

  logic [ADDR_W:0] wptr_q, wptr_d;
  logic [ADDR_W:0] rptr_q, rptr_d;
  logic [ADDR_W:0] level_q, level_d;
  logic            r_valid_q, r_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            full, empty, push_ok, pop_ok;

  always_comb begin
    full        = (level_q == DEPTH);
    empty       = (level_q == '0);
    push_ok     = bus.w_en & ~full & ~rst;
    pop_ok      = bus.r_en & ~empty & ~rst;
    wptr_d      = push_ok ? wptr_q + ONE : wptr_q;
    rptr_d      = pop_ok ? rptr_q + ONE : rptr_q;
    level_d     = level_q;
    if (push_ok && !pop_ok) begin
      level_d = level_q + ONE;
    end else if (!push_ok && pop_ok) begin
      level_d = level_q - ONE;
    end
    r_valid_d   = pop_ok;
    overflow_d  = overflow_q | (bus.w_en & full);
    underflow_d = underflow_q | (bus.r_en & empty);
    // Flush wins over any request presented in the same cycle.
    if (rst) begin
      wptr_d      = '0;
      rptr_d      = '0;
      level_d     = '0;
      r_valid_d   = 1'b0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      r_valid_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      r_valid_q   <= r_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.w_full         = full;
  assign bus.w_almost_full  = (level_q >= AF_LVL);
  assign bus.r_empty        = empty;
  assign bus.r_almost_empty = (level_q <= AE_LVL);
  assign bus.level          = level_q;
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;
  assign bus.r_valid        = r_valid_q;
  assign bus.r_data         = bus.ext_mem_r_data;

  assign bus.ext_mem_w_en   = push_ok;
  assign bus.ext_mem_w_addr = wptr_q[ADDR_W-1:0];
  assign bus.ext_mem_w_data = bus.w_data;
  assign bus.ext_mem_r_en   = pop_ok;
  assign bus.ext_mem_r_addr = rptr_q[ADDR_W-1:0];

  // The extra pointer bit keeps the pointer distance equal to the stored level.
  assert property (@(posedge clk) disable iff (!arst_n) (wptr_q - rptr_q) == level_q);

endmodule

// File: tb/tb_iob_fifo_sync_ctrl.sv
// Directed bench for iob_fifo_sync_ctrl with a behavioural 1-cycle-latency 2-port RAM.
module tb_iob_fifo_sync_ctrl;

  logic clk;
  logic arst_n;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [0:15];

  iob_fifo_sync_ctrl_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  iob_fifo_sync_ctrl #(
    .DATA_W(8), .ADDR_W(4), .ALMOST_FULL_LVL(14), .ALMOST_EMPTY_LVL(2)
  ) dut (
    .clk(clk),
    .arst_n(arst_n),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ext_mem_w_en) mem[bus.ext_mem_w_addr] <= bus.ext_mem_w_data;
    if (bus.ext_mem_r_en) bus.ext_mem_r_data <= mem[bus.ext_mem_r_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0;
    rst = 1'b0;
    bus.w_en = 1'b0;
    bus.w_data = 8'd0;
    bus.r_en = 1'b0;
    #2;
    chk("rst_empty", bus.r_empty, 1);
    chk("rst_full", bus.w_full, 0);
    chk("rst_level", bus.level, 0);
    chk("rst_rvalid", bus.r_valid, 0);
    chk("rst_wen", bus.ext_mem_w_en, 0);
    chk("rst_ren", bus.ext_mem_r_en, 0);
    chk("rst_aempty", bus.r_almost_empty, 1);
    chk("rst_afull", bus.w_almost_full, 0);
    cyc();
    arst_n = 1'b1;
    cyc();

    // Fill with 32..47
    for (int i = 0; i < 16; i++) begin
      bus.w_en = 1'b1;
      bus.w_data = 8'(32 + i);
      #1;
      chk("fill_wen", bus.ext_mem_w_en, 1);
      chk("fill_waddr", bus.ext_mem_w_addr, i);
      chk("fill_wdata", bus.ext_mem_w_data, 32 + i);
      cyc();
      chk("fill_level", bus.level, i + 1);
      chk("fill_afull", bus.w_almost_full, (i + 1 >= 14) ? 1 : 0);
      chk("fill_full", bus.w_full, (i + 1 == 16) ? 1 : 0);
    end

    // Push while full
    bus.w_data = 8'd99;
    #1;
    chk("ovf_wen", bus.ext_mem_w_en, 0);
    cyc();
    bus.w_en = 1'b0;
    chk("ovf_level", bus.level, 16);
    chk("ovf_flag", bus.overflow, 1);
    cyc();
    cyc();
    chk("ovf_sticky", bus.overflow, 1);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      bus.r_en = 1'b1;
      #1;
      chk("drain_ren", bus.ext_mem_r_en, 1);
      chk("drain_raddr", bus.ext_mem_r_addr, i);
      cyc();
      chk("drain_rvalid", bus.r_valid, 1);
      chk("drain_rdata", bus.r_data, 32 + i);
      chk("drain_aempty", bus.r_almost_empty, (15 - i <= 2) ? 1 : 0);
    end
    chk("drain_empty", bus.r_empty, 1);
    chk("drain_level", bus.level, 0);
    #1;
    chk("udf_ren", bus.ext_mem_r_en, 0);
    cyc();
    bus.r_en = 1'b0;
    chk("udf_flag", bus.underflow, 1);
    chk("udf_rvalid", bus.r_valid, 0);

    // Flush clears sticky flags
    flush();
    chk("fl_ovf", bus.overflow, 0);
    chk("fl_udf", bus.underflow, 0);
    chk("fl_level", bus.level, 0);

    // Empty + push + pop: push only, underflow set
    bus.w_en = 1'b1;
    bus.r_en = 1'b1;
    bus.w_data = 8'd64;
    #1;
    chk("ep_wen", bus.ext_mem_w_en, 1);
    chk("ep_ren", bus.ext_mem_r_en, 0);
    cyc();
    bus.r_en = 1'b0;
    chk("ep_level", bus.level, 1);
    chk("ep_udf", bus.underflow, 1);
    chk("ep_rvalid", bus.r_valid, 0);

    // Bring level to 15 with 65..78
    for (int i = 0; i < 14; i++) begin
      bus.w_data = 8'(65 + i);
      cyc();
    end
    chk("l15_level", bus.level, 15);
    chk("l15_afull", bus.w_almost_full, 1);
    chk("l15_full", bus.w_full, 0);

    // Streaming push+pop across pointer wrap
    bus.r_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.w_data = 8'(79 + i);
      #1;
      chk("st_waddr", bus.ext_mem_w_addr, (15 + i) % 16);
      chk("st_raddr", bus.ext_mem_r_addr, i % 16);
      cyc();
      chk("st_level", bus.level, 15);
      chk("st_rvalid", bus.r_valid, 1);
      chk("st_rdata", bus.r_data, 64 + i);
    end
    chk("st_ovf", bus.overflow, 0);

    // Top up to full, then full + push + pop
    bus.r_en = 1'b0;
    bus.w_data = 8'd200;
    cyc();
    chk("fp_full", bus.w_full, 1);
    bus.r_en = 1'b1;
    bus.w_data = 8'd201;
    #1;
    chk("fp_wen", bus.ext_mem_w_en, 0);
    chk("fp_ren", bus.ext_mem_r_en, 1);
    cyc();
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    chk("fp_level", bus.level, 15);
    chk("fp_ovf", bus.overflow, 1);
    chk("fp_rdata", bus.r_data, 84);

    // Mid-operation flush with requests asserted
    flush();
    for (int i = 0; i < 5; i++) begin
      bus.w_en = 1'b1;
      bus.w_data = 8'(1 + i);
      cyc();
    end
    bus.w_en = 1'b0;
    bus.r_en = 1'b1;
    cyc();
    chk("mf_pop_rvalid", bus.r_valid, 1);
    chk("mf_pop_rdata", bus.r_data, 1);
    bus.w_en = 1'b1;
    bus.w_data = 8'd55;
    rst = 1'b1;
    #1;
    chk("mf_wen", bus.ext_mem_w_en, 0);
    chk("mf_ren", bus.ext_mem_r_en, 0);
    cyc();
    rst = 1'b0;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    chk("mf_level", bus.level, 0);
    chk("mf_empty", bus.r_empty, 1);
    chk("mf_rvalid", bus.r_valid, 0);
    chk("mf_ovf", bus.overflow, 0);
    chk("mf_udf", bus.underflow, 0);

    bus.w_en = 1'b1;
    bus.w_data = 8'd7;
    #1;
    chk("mf_waddr", bus.ext_mem_w_addr, 0);
    cyc();
    bus.w_en = 1'b0;
    bus.r_en = 1'b1;
    cyc();
    bus.r_en = 1'b0;
    chk("mf_rvalid7", bus.r_valid, 1);
    chk("mf_rdata7", bus.r_data, 7);
    chk("mf_level_end", bus.level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
